// File: rtl/rv_pkg.sv
// Shared writeback types: result-select encoding and queue entry layout.
package rv_pkg;

    localparam int unsigned RV_WAD = 5;
    localparam int unsigned RV_WD  = 32;

    // Result select; 2'b11 is not named and falls back to the ALU result.
    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } resultsrc_e;

    typedef struct packed {
        logic [RV_WAD-1:0] rd;
        logic [RV_WD-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO holding long-latency results waiting for a free write-port cycle.
// Push when full and pop when empty are ignored.
module wb_fifo
    import rv_pkg::*;
#(
    parameter type         T     = wb_entry_t,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  T              din_i,
    input  logic          pop_i,
    output T              dout_o,
    output logic [CW-1:0] count_o
);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    // Pointer wrap, occupancy bookkeeping.
    always_comb begin
        push_ok = push_i && (cnt_q != CW'(DEPTH));
        pop_ok  = pop_i && (cnt_q != '0);
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (push_ok) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        if (pop_ok)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Pointer and count registers; reset empties the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: MEM/WB pipeline slot shares the register-file write port
// with a queue of long-latency (mul/div) results. The pipeline always wins.
// Define WB_SCOREBOARD_EN to build the per-register pending-write scoreboard;
// otherwise busy is tied low.
module wb_arbiter
    import rv_pkg::*;
#(
    parameter int unsigned WAD   = 5,
    parameter int unsigned WD    = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              regwriteM,
    input  logic [WAD-1:0]    rdM,
    input  logic [1:0]        resultsrcM,
    input  logic [WD-1:0]     aluresultM,
    input  logic [WD-1:0]     readdataM,
    input  logic [WD-1:0]     pcplus4M,
    input  logic              flushW,
    input  logic              lu_valid,
    input  logic [WAD-1:0]    lu_rd,
    input  logic [WD-1:0]     lu_data,
    output logic              lu_ready,
    input  logic              lu_issue,
    input  logic [WAD-1:0]    lu_issue_rd,
    output logic              regwriteW,
    output logic [WAD-1:0]    rdW,
    output logic [WD-1:0]     resultW,
    output logic [2**WAD-1:0] busy,
    output logic [CW-1:0]     pending
);

    // Same layout as wb_entry_t, sized to this instance's widths.
    typedef struct packed {
        logic [WAD-1:0] rd;
        logic [WD-1:0]  data;
    } entry_t;

    logic           slot_vld_q, slot_vld_d;
    logic [WAD-1:0] slot_rd_q, slot_rd_d;
    logic [WD-1:0]  slot_data_q, slot_data_d;
    logic           lu_push, lu_pop;
    entry_t         lu_in, lu_head;

    // Select the stage result and qualify the write before capture.
    always_comb begin
        slot_vld_d = regwriteM && (rdM != '0) && !flushW;
        slot_rd_d  = rdM;
        case (resultsrcM)
            RES_LOAD: slot_data_d = readdataM;
            RES_PC4:  slot_data_d = pcplus4M;
            default:  slot_data_d = aluresultM;
        endcase
    end

    // MEM/WB slot register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_vld_q  <= 1'b0;
            slot_rd_q   <= '0;
            slot_data_q <= '0;
        end else begin
            slot_vld_q  <= slot_vld_d;
            slot_rd_q   <= slot_rd_d;
            slot_data_q <= slot_data_d;
        end
    end

    assign lu_ready   = rst_n && (pending < CW'(DEPTH));
    assign lu_push    = lu_valid && lu_ready && (lu_rd != '0);
    assign lu_pop     = !slot_vld_q && (pending != '0);
    assign lu_in.rd   = lu_rd;
    assign lu_in.data = lu_data;

    wb_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (lu_push),
        .din_i   (lu_in),
        .pop_i   (lu_pop),
        .dout_o  (lu_head),
        .count_o (pending)
    );

    // Write-port mux: pipeline slot first, then queue head, else quiet zeros.
    always_comb begin
        regwriteW = 1'b0;
        rdW       = '0;
        resultW   = '0;
        if (slot_vld_q) begin
            regwriteW = 1'b1;
            rdW       = slot_rd_q;
            resultW   = slot_data_q;
        end else if (lu_pop) begin
            regwriteW = 1'b1;
            rdW       = lu_head.rd;
            resultW   = lu_head.data;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [2**WAD-1:0] busy_q, busy_d;

    // Clear on queue writeback, then set on issue so a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (lu_pop)   busy_d[lu_head.rd]  = 1'b0;
        if (lu_issue) busy_d[lu_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy = busy_q;
`else
    logic unused_issue;
    assign unused_issue = ^{lu_issue, lu_issue_rd};
    assign busy         = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: expected register-file writes are queued
// as stimulus is driven and compared in order as the write port fires.
module tb_wb_arbiter;

    localparam int unsigned WAD   = 5;
    localparam int unsigned WD    = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              regwriteM;
    logic [WAD-1:0]    rdM;
    logic [1:0]        resultsrcM;
    logic [WD-1:0]     aluresultM, readdataM, pcplus4M;
    logic              flushW;
    logic              lu_valid;
    logic [WAD-1:0]    lu_rd;
    logic [WD-1:0]     lu_data;
    logic              lu_ready;
    logic              lu_issue;
    logic [WAD-1:0]    lu_issue_rd;
    logic              regwriteW;
    logic [WAD-1:0]    rdW;
    logic [WD-1:0]     resultW;
    logic [2**WAD-1:0] busy;
    logic [CW-1:0]     pending;

    typedef struct {
        logic [WAD-1:0] rd;
        logic [WD-1:0]  data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    wb_arbiter #(
        .WAD   (WAD),
        .WD    (WD),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .regwriteM   (regwriteM),
        .rdM         (rdM),
        .resultsrcM  (resultsrcM),
        .aluresultM  (aluresultM),
        .readdataM   (readdataM),
        .pcplus4M    (pcplus4M),
        .flushW      (flushW),
        .lu_valid    (lu_valid),
        .lu_rd       (lu_rd),
        .lu_data     (lu_data),
        .lu_ready    (lu_ready),
        .lu_issue    (lu_issue),
        .lu_issue_rd (lu_issue_rd),
        .regwriteW   (regwriteW),
        .rdW         (rdW),
        .resultW     (resultW),
        .busy        (busy),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WD-1:0] model_sel(input logic [1:0] src, input logic [WD-1:0] alu,
                                                input logic [WD-1:0] ld, input logic [WD-1:0] pc);
        case (src)
            2'b01:   return ld;
            2'b10:   return pc;
            default: return alu;
        endcase
    endfunction

    // Compare the write port against the head of the expected-write queue.
    task automatic check_wb();
        exp_t e;
        if (regwriteW) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected_write", {59'd0, rdW}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("wb_rd", 64'(rdW), 64'(e.rd));
                check("wb_data", 64'(resultW), 64'(e.data));
            end
        end else begin
            check("wb_idle_rd", 64'(rdW), 64'd0);
            check("wb_idle_data", 64'(resultW), 64'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_wb();
    endtask

    task automatic idle_m();
        regwriteM  = 1'b0;
        rdM        = '0;
        resultsrcM = 2'b00;
        aluresultM = '0;
        readdataM  = '0;
        pcplus4M   = '0;
        flushW     = 1'b0;
    endtask

    task automatic set_m(input logic we, input logic [WAD-1:0] rd, input logic [1:0] src,
                         input logic [WD-1:0] alu, input logic [WD-1:0] ld,
                         input logic [WD-1:0] pc, input logic flush);
        regwriteM  = we;
        rdM        = rd;
        resultsrcM = src;
        aluresultM = alu;
        readdataM  = ld;
        pcplus4M   = pc;
        flushW     = flush;
    endtask

    // Drive a valid pipeline write and record the expected writeback.
    task automatic pipe_write(input logic [WAD-1:0] rd, input logic [1:0] src);
        logic [WD-1:0] alu, ld, pc;
        alu = 32'hA000_0000 | 32'(rd);
        ld  = 32'hB000_0000 | 32'(rd);
        pc  = 32'hC000_0000 | 32'(rd);
        set_m(1'b1, rd, src, alu, ld, pc, 1'b0);
        exp_q.push_back('{rd, model_sel(src, alu, ld, pc)});
    endtask

    task automatic set_lu(input logic v, input logic [WAD-1:0] rd, input logic [WD-1:0] d);
        lu_valid = v;
        lu_rd    = rd;
        lu_data  = d;
    endtask

    initial begin
        rst_n       = 1'b0;
        idle_m();
        set_lu(1'b0, '0, '0);
        lu_issue    = 1'b0;
        lu_issue_rd = '0;

        // Reset state
        step();
        step();
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_lu_ready", 64'(lu_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        step();
        check("rel_lu_ready", 64'(lu_ready), 64'd1);
        check("rel_pending", 64'(pending), 64'd0);

        // Load result path, then each remaining select code
        set_m(1'b1, 5'd7, 2'b01, 32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222, 1'b0);
        exp_q.push_back('{5'd7, 32'hDEAD_BEEF});
        step();
        check("load_regwriteW", 64'(regwriteW), 64'd1);
        pipe_write(5'd3, 2'b00);
        step();
        pipe_write(5'd4, 2'b10);
        step();
        pipe_write(5'd5, 2'b11);
        step();

        // Suppressed writes: rd 0, flush, no write enable
        set_m(1'b1, 5'd0, 2'b00, 32'h3333_3333, '0, '0, 1'b0);
        step();
        set_m(1'b1, 5'd6, 2'b00, 32'h4444_4444, '0, '0, 1'b1);
        step();
        check("flush_regwriteW", 64'(regwriteW), 64'd0);
        set_m(1'b0, 5'd8, 2'b00, 32'h5555_5555, '0, '0, 1'b0);
        step();
        idle_m();
        step();
        check("idle_regwriteW", 64'(regwriteW), 64'd0);

        // Queue write held off by three back-to-back pipeline writes
        pipe_write(5'd1, 2'b00);
        set_lu(1'b1, 5'd9, 32'h55);
        step();
        set_lu(1'b0, '0, '0);
        check("hold_pending0", 64'(pending), 64'd1);
        pipe_write(5'd2, 2'b00);
        step();
        pipe_write(5'd3, 2'b01);
        step();
        check("hold_pending2", 64'(pending), 64'd1);
        idle_m();
        exp_q.push_back('{5'd9, 32'h55});
        step();
        check("hold_pop_pending", 64'(pending), 64'd1);
        step();
        check("hold_drained", 64'(pending), 64'd0);

        // Fill the queue while pops are blocked; a third offer is refused
        pipe_write(5'd2, 2'b00);
        set_lu(1'b1, 5'd10, 32'hA1);
        step();
        pipe_write(5'd3, 2'b00);
        set_lu(1'b1, 5'd11, 32'hA2);
        step();
        check("full_pending", 64'(pending), 64'd2);
        check("full_lu_ready", 64'(lu_ready), 64'd0);
        pipe_write(5'd4, 2'b00);
        set_lu(1'b1, 5'd13, 32'hA3);
        step();
        check("full_refused", 64'(pending), 64'd2);
        idle_m();
        set_lu(1'b0, '0, '0);
        exp_q.push_back('{5'd10, 32'hA1});
        exp_q.push_back('{5'd11, 32'hA2});
        step();
        check("pop1_lu_ready_same", 64'(lu_ready), 64'd0);
        step();
        check("pop1_lu_ready_next", 64'(lu_ready), 64'd1);
        check("pop1_pending", 64'(pending), 64'd1);
        step();
        check("full_drained", 64'(pending), 64'd0);

        // rd 0 result is accepted but discarded
        set_lu(1'b1, 5'd0, 32'hBAD);
        step();
        set_lu(1'b0, '0, '0);
        check("rd0_pending", 64'(pending), 64'd0);
        step();

        // Push and pop in the same cycle keeps count and order
        set_lu(1'b1, 5'd14, 32'hE1);
        exp_q.push_back('{5'd14, 32'hE1});
        step();
        set_lu(1'b1, 5'd15, 32'hE2);
        exp_q.push_back('{5'd15, 32'hE2});
        step();
        set_lu(1'b0, '0, '0);
        check("pushpop_pending", 64'(pending), 64'd1);
        step();
        check("pushpop_drained", 64'(pending), 64'd0);

        // Scoreboard set / clear / set-wins
        lu_issue    = 1'b1;
        lu_issue_rd = 5'd12;
        step();
        lu_issue = 1'b0;
        check("busy12_set", 64'(busy[12]), 64'(SB));
        set_lu(1'b1, 5'd12, 32'h1234);
        exp_q.push_back('{5'd12, 32'h1234});
        step();
        set_lu(1'b0, '0, '0);
        check("busy12_during_wb", 64'(busy[12]), 64'(SB));
        step();
        check("busy12_cleared", 64'(busy), 64'd0);
        lu_issue    = 1'b1;
        lu_issue_rd = 5'd12;
        step();
        lu_issue = 1'b0;
        set_lu(1'b1, 5'd12, 32'h5678);
        exp_q.push_back('{5'd12, 32'h5678});
        step();
        set_lu(1'b0, '0, '0);
        lu_issue    = 1'b1;
        lu_issue_rd = 5'd12;
        step();
        lu_issue    = 1'b0;
        lu_issue_rd = 5'd0;
        check("busy12_set_wins", 64'(busy[12]), 64'(SB));
        lu_issue = 1'b1;
        step();
        lu_issue = 1'b0;
        check("busy0_zero", 64'(busy[0]), 64'd0);
        check("busy_only12", 64'(busy), SB ? 64'h1000 : 64'd0);

        // Reset with a full queue drops the entries
        pipe_write(5'd20, 2'b00);
        set_lu(1'b1, 5'd21, 32'hF1);
        step();
        pipe_write(5'd22, 2'b00);
        set_lu(1'b1, 5'd23, 32'hF2);
        step();
        check("prerst_pending", 64'(pending), 64'd2);
        idle_m();
        set_lu(1'b0, '0, '0);
        rst_n = 1'b0;
        step();
        check("rst2_regwriteW", 64'(regwriteW), 64'd0);
        check("rst2_pending", 64'(pending), 64'd0);
        check("rst2_lu_ready", 64'(lu_ready), 64'd0);
        check("rst2_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        step();
        check("rel2_lu_ready", 64'(lu_ready), 64'd1);
        step();
        step();
        check("rel2_pending", 64'(pending), 64'd0);
        check("all_writes_seen", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
- REQ-001 SHALL have parameter WAD, default 5: register-address width.
- REQ-002 SHALL have parameter WD, default 32: data width.
- REQ-003 SHALL have parameter DEPTH, default 2: long-latency result queue depth.
- REQ-004 SHALL have one clock and a synchronous active-low reset; ports follow.
- REQ-005 SHALL have port clk, input, 1: rising-edge clock.
- REQ-006 SHALL have port rst_n, input, 1: synchronous active-low reset.
- REQ-007 SHALL have port regwriteM, input, 1: memory-stage write enable.
- REQ-008 SHALL have port rdM, input, WAD: memory-stage destination register.
- REQ-009 SHALL have port resultsrcM, input, 2: result select (00 ALU, 01 load, 10 PC+4, 11 ALU).
- REQ-010 SHALL have ports aluresultM, readdataM and pcplus4M, input, WD each: result candidates.
- REQ-011 SHALL have port flushW, input, 1: kills the instruction entering writeback.
- REQ-012 SHALL have ports lu_valid (input, 1), lu_rd (input, WAD), lu_data (input, WD) and lu_ready (output, 1): long-latency (mul/div) result handshake.
- REQ-013 SHALL have ports lu_issue (input, 1) and lu_issue_rd (input, WAD): long-latency op issued.
- REQ-014 SHALL have ports regwriteW (output, 1), rdW (output, WAD) and resultW (output, WD): register-file write port.
- REQ-015 SHALL have port busy, output, 2**WAD: per-register pending-write scoreboard.
- REQ-016 SHALL have port pending, output, $clog2(DEPTH+1): queue occupancy.

Function
- REQ-017 SHALL register the M inputs each cycle into a MEM/WB slot; slot valid = regwriteM && rdM!=0 && !flushW.
- REQ-018 SHALL mux the captured result by resultsrcM before registering; latency from M inputs to W outputs is 1 cycle.
- REQ-019 SHALL accept a long-latency result when lu_valid && lu_ready; lu_ready = (pending < DEPTH), from registered count only.
- REQ-020 SHALL discard, and not enqueue, an accepted result with lu_rd==0.
- REQ-021 SHALL keep queue order FIFO; head entry written no earlier than the cycle after acceptance.
- REQ-022 SHALL give a valid MEM/WB slot absolute priority on the write port; the queue head pops only in a cycle with no valid slot.
- REQ-023 SHALL, when a push and a pop occur in the same cycle, leave pending unchanged and keep order.
- REQ-024 SHALL drive regwriteW=0, rdW=0 and resultW=0 in a cycle with no write.
- REQ-025 SHALL set busy[lu_issue_rd] on the cycle after lu_issue; busy[0] is constant 0.
- REQ-026 SHALL clear busy[r] on the cycle after the queue entry for r is driven on the W port.
- REQ-027 SHALL let set win when a set and a clear target the same register in the same cycle.
- REQ-028 SHALL not detect WAW between pipeline and queue writes; hazard unit stalls on busy.

Reset
- REQ-029 SHALL, while rst_n=0 at the clock edge, clear the slot and queue, set pending=0, busy=0, regwriteW=0, rdW=0, resultW=0.
- REQ-030 SHALL hold lu_ready=0 during reset and 1 on the first cycle after release; in-flight queue entries are lost.

Configuration
- REQ-031 SHALL compile in the scoreboard when WB_SCOREBOARD_EN is defined (REQ-025..027); when undefined, busy is tied to 0 and no scoreboard flops exist.

Structure
- REQ-032 SHALL place the resultsrc enum (ALU, LOAD, PC4) and the wb_entry_t struct {rd, data} in shared package rv_pkg.
- REQ-033 SHALL implement the queue as sub-module wb_fifo (DEPTH entries of wb_entry_t, push/pop/count).

Verification
- REQ-034 SHALL verify: regwriteM=1, rdM=7, resultsrcM=01, readdataM=0xDEADBEEF -> next cycle regwriteW=1, rdW=7, resultW=0xDEADBEEF.
- REQ-035 SHALL verify: rdM=0 or flushW=1 with regwriteM=1 -> regwriteW=0 the next cycle.
- REQ-036 SHALL verify: lu push rd=9, data=0x55 while the pipeline writes for 3 cycles -> queue write is delayed until the first idle cycle, then rdW=9, resultW=0x55.
- REQ-037 SHALL verify: 2 pushes with a blocked pop -> pending=2, lu_ready=0; 1 pop -> lu_ready=1 the next cycle; write order preserved.
- REQ-038 SHALL verify: lu_issue rd=12 -> busy[12]=1 next cycle; cleared the cycle after rdW=12 from the queue; a same-cycle re-issue keeps busy[12]=1.
- REQ-039 SHALL verify: rst_n=0 with pending=2 -> all outputs 0, pending=0, and the queue is empty after release.
